marble_launcher: RTL and testbench

- Drives a Turing Tumble puzzle board over repeated ball runs. Sits directly upstream of the puzzle and also consumes its per-ball result.
- Holds blue and red hopper counts and issues a one-cycle start pulse that releases one ball.
- Waits for the puzzle to report the exit lever or the interceptor, then releases the next ball of the colour chosen by the exit lever.
- Records the colour sequence of balls collected in the output tray.

---
 rtl/marble_launcher_pkg.sv | 15 +
 rtl/marble_hopper.sv | 28 ++
 rtl/marble_launcher.sv | 116 +++++++++++
 tb/tb_marble_launcher.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/marble_launcher_pkg.sv
// Shared constants for the marble launcher:
// FSM encoding, ball colours and hopper count width.
package marble_launcher_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic BLUE = 1'b0;
    localparam logic RED  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/marble_hopper.sv
// Loadable ball hopper: a down-counter that
// reloads to INIT and stops at zero.
module marble_hopper
    import marble_launcher_pkg::*;
#(
    parameter int INIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= CNT_W'(INIT);
        end else if (load) begin
            count <= CNT_W'(INIT);
        end else if (dec && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/marble_launcher.sv
// Ball release sequencer for a Turing Tumble board:
// launches balls, follows the exit lever, logs the tray.
module marble_launcher
    import marble_launcher_pkg::*;
#(
    parameter int BLUE_BALLS = 8,
    parameter int RED_BALLS  = 8,
    parameter int SEQ_DEPTH  = 16,
    parameter int TIMEOUT    = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 first_colour,
    input  logic                 ball_exit,
    input  logic                 exit_colour,
    input  logic                 stopped,
    output logic                 start,
    output logic                 ball_colour,
    output logic                 busy,
    output logic                 done,
    output logic                 jam,
    output logic [CNT_W-1:0]     blue_left,
    output logic [CNT_W-1:0]     red_left,
    output logic [4:0]           out_count,
    output logic [SEQ_DEPTH-1:0] out_seq
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic          sel;
    logic [TW-1:0] tcnt;
    logic          blue_empty;
    logic          red_empty;
    logic          sel_empty;
    logic          reload;
    logic          fire;

    assign reload    = go && (state == S_IDLE || state == S_DONE);
    assign sel_empty = (sel == RED) ? red_empty : blue_empty;
    assign fire      = (state == S_LAUNCH) && !sel_empty;
    assign busy      = (state == S_LAUNCH) || (state == S_WAIT);
    assign done      = (state == S_DONE);

    marble_hopper #(.INIT(BLUE_BALLS)) u_blue (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (reload),
        .dec   (fire && sel == BLUE),
        .count (blue_left),
        .empty (blue_empty)
    );

    marble_hopper #(.INIT(RED_BALLS)) u_red (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (reload),
        .dec   (fire && sel == RED),
        .count (red_left),
        .empty (red_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sel         <= BLUE;
            tcnt        <= '0;
            start       <= 1'b0;
            ball_colour <= BLUE;
            jam         <= 1'b0;
            out_count   <= '0;
            out_seq     <= '0;
        end else begin
            start <= fire;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        sel       <= first_colour;
                        jam       <= 1'b0;
                        out_count <= '0;
                        out_seq   <= '0;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (!sel_empty) begin
                        ball_colour <= sel;
                        tcnt        <= '0;
                        state       <= S_WAIT;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_WAIT: begin
                    tcnt <= tcnt + TW'(1);
                    // interceptor beats a simultaneous lever hit
                    if (stopped) begin
                        state <= S_DONE;
                    end else if (ball_exit) begin
                        out_seq <= {out_seq[SEQ_DEPTH-2:0], ball_colour};
                        if (out_count != 5'd31) begin
                            out_count <= out_count + 5'd1;
                        end
                        sel   <= exit_colour;
                        state <= S_LAUNCH;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        jam   <= 1'b1;
                        state <= S_DONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_marble_launcher.sv
// Directed bench for marble_launcher: full runs,
// alternating levers, interceptor, jam and reset.
module tb_marble_launcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        first_colour;
    logic        ball_exit;
    logic        exit_colour;
    logic        stopped;
    logic        start;
    logic        ball_colour;
    logic        busy;
    logic        done;
    logic        jam;
    logic [3:0]  blue_left;
    logic [3:0]  red_left;
    logic [4:0]  out_count;
    logic [15:0] out_seq;

    int total = 0;
    int bad   = 0;

    marble_launcher dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .first_colour (first_colour),
        .ball_exit    (ball_exit),
        .exit_colour  (exit_colour),
        .stopped      (stopped),
        .start        (start),
        .ball_colour  (ball_colour),
        .busy         (busy),
        .done         (done),
        .jam          (jam),
        .blue_left    (blue_left),
        .red_left     (red_left),
        .out_count    (out_count),
        .out_seq      (out_seq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_go(input logic fc);
        first_colour = fc;
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic wait_start(input int limit, output int w);
        w = -1;
        for (int i = 1; i <= limit; i++) begin
            if (w < 0) begin
                step();
                if (start === 1'b1) w = i;
            end
        end
    endtask

    // Plays the puzzle: replies 3 cycles after each start.
    task automatic run_balls(
        input  logic        fc,
        input  logic [31:0] pattern,
        input  int          stop_at,
        input  logic        both,
        output int          starts,
        output logic [31:0] seen,
        output int          errs
    );
        int  w;
        bit  fin;
        starts = 0;
        seen   = '0;
        errs   = 0;
        fin    = 0;
        do_go(fc);
        wait_start(4, w);
        if (w != 1) errs++;
        while (w > 0 && !fin && starts < 20) begin
            seen[starts] = ball_colour;
            starts++;
            step();
            if (start !== 1'b0) errs++;
            step();
            step();
            if (starts - 1 == stop_at) begin
                stopped     = 1'b1;
                ball_exit   = both;
                exit_colour = 1'b0;
            end else begin
                ball_exit   = 1'b1;
                exit_colour = pattern[starts-1];
            end
            step();
            ball_exit = 1'b0;
            if (stopped) begin
                stopped = 1'b0;
                fin = 1;
                wait_start(6, w);
                if (w > 0) errs++;
            end else begin
                wait_start(6, w);
                if (w > 0 && w != 1) errs++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({start, busy, done, jam, ball_colour} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=00000",
                     {start, busy, done, jam, ball_colour});
        end
        step();
        step();
        rst_n = 1'b1;
        total++;
        if ({blue_left, red_left, out_count, out_seq} !== {4'd8, 4'd8, 5'd0, 16'd0}) begin
            bad++;
            $display("FAIL reset_counts got=%0d/%0d/%0d/%h want=8/8/0/0000",
                     blue_left, red_left, out_count, out_seq);
        end
        step();
        step();
        total++;
        if ({start, busy, done} !== 3'b0) begin
            bad++;
            $display("FAIL reset_idle got=%b want=000", {start, busy, done});
        end
    endtask

    task automatic test_default_run();
        int starts, errs;
        logic [31:0] seen;
        run_balls(1'b0, 32'h0, -1, 1'b0, starts, seen, errs);
        total++;
        if (starts !== 8) begin
            bad++;
            $display("FAIL default_starts got=%0d want=8", starts);
        end
        total++;
        if (seen[15:0] !== 16'h0000 || errs !== 0) begin
            bad++;
            $display("FAIL default_colours got=%h errs=%0d want=0000 errs=0",
                     seen[15:0], errs);
        end
        total++;
        if ({done, busy} !== 2'b10) begin
            bad++;
            $display("FAIL default_done got=%b want=10", {done, busy});
        end
        total++;
        if ({blue_left, red_left} !== {4'd0, 4'd8}) begin
            bad++;
            $display("FAIL default_hoppers got=%0d/%0d want=0/8",
                     blue_left, red_left);
        end
        total++;
        if (out_count !== 5'd8 || out_seq !== 16'h0000) begin
            bad++;
            $display("FAIL default_tray got=%0d/%h want=8/0000",
                     out_count, out_seq);
        end
    endtask

    task automatic test_alternate();
        int starts, errs;
        logic [31:0] seen;
        run_balls(1'b0, 32'h0000_5555, -1, 1'b0, starts, seen, errs);
        total++;
        if (starts !== 16) begin
            bad++;
            $display("FAIL alt_starts got=%0d want=16", starts);
        end
        total++;
        if (seen[15:0] !== 16'hAAAA) begin
            bad++;
            $display("FAIL alt_colours got=%h want=aaaa", seen[15:0]);
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL alt_latency got=%0d errors want=0", errs);
        end
        total++;
        if (out_seq !== 16'h5555 || out_count !== 5'd16) begin
            bad++;
            $display("FAIL alt_tray got=%h/%0d want=5555/16",
                     out_seq, out_count);
        end
        total++;
        if ({blue_left, red_left, done} !== {4'd0, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL alt_end got=%0d/%0d/%b want=0/0/1",
                     blue_left, red_left, done);
        end
    endtask

    task automatic test_stopped();
        int starts, errs;
        logic [31:0] seen;
        run_balls(1'b1, 32'h0000_0002, 2, 1'b0, starts, seen, errs);
        total++;
        if (starts !== 3 || seen[2:0] !== 3'b101 || errs !== 0) begin
            bad++;
            $display("FAIL stop_starts got=%0d/%b/%0d want=3/101/0",
                     starts, seen[2:0], errs);
        end
        total++;
        if ({done, out_count, out_seq} !== {1'b1, 5'd2, 16'h0002}) begin
            bad++;
            $display("FAIL stop_tray got=%b/%0d/%h want=1/2/0002",
                     done, out_count, out_seq);
        end
        total++;
        if ({blue_left, red_left} !== {4'd7, 4'd6}) begin
            bad++;
            $display("FAIL stop_hoppers got=%0d/%0d want=7/6",
                     blue_left, red_left);
        end
    endtask

    task automatic test_both();
        int starts, errs;
        logic [31:0] seen;
        run_balls(1'b0, 32'h0, 0, 1'b1, starts, seen, errs);
        total++;
        if (starts !== 1 || errs !== 0) begin
            bad++;
            $display("FAIL both_starts got=%0d/%0d want=1/0", starts, errs);
        end
        total++;
        if ({done, out_count, blue_left, red_left} !== {1'b1, 5'd0, 4'd7, 4'd8}) begin
            bad++;
            $display("FAIL both_state got=%b/%0d/%0d/%0d want=1/0/7/8",
                     done, out_count, blue_left, red_left);
        end
    endtask

    task automatic test_jam();
        int w, cnt, extra;
        do_go(1'b0);
        wait_start(4, w);
        total++;
        if (w !== 1) begin
            bad++;
            $display("FAIL jam_first_start got=%0d want=1", w);
        end
        cnt = -1;
        extra = 0;
        for (int k = 1; k <= 40; k++) begin
            if (cnt < 0) begin
                step();
                if (start === 1'b1) extra++;
                if (jam === 1'b1) cnt = k;
                go = (k == 5);
                first_colour = 1'b1;
            end
        end
        go = 1'b0;
        total++;
        if (cnt !== 31 || extra !== 0) begin
            bad++;
            $display("FAIL jam_delay got=%0d extra=%0d want=31 extra=0",
                     cnt, extra);
        end
        total++;
        if ({done, busy} !== 2'b10) begin
            bad++;
            $display("FAIL jam_done got=%b want=10", {done, busy});
        end
        do_go(1'b1);
        total++;
        if ({jam, done, busy} !== 3'b001) begin
            bad++;
            $display("FAIL jam_clear got=%b want=001", {jam, done, busy});
        end
        wait_start(4, w);
        total++;
        if (w !== 1 || ball_colour !== 1'b1 || red_left !== 4'd7) begin
            bad++;
            $display("FAIL jam_restart got=%0d/%b/%0d want=1/1/7",
                     w, ball_colour, red_left);
        end
    endtask

    task automatic test_reset_mid_wait();
        int starts, w;
        step();
        step();
        rst_n = 1'b0;
        #2;
        total++;
        if ({start, busy, done, jam, ball_colour} !== 5'b0 ||
            {blue_left, red_left} !== {4'd8, 4'd8}) begin
            bad++;
            $display("FAIL midreset_async got=%b %0d/%0d want=00000 8/8",
                     {start, busy, done, jam, ball_colour}, blue_left, red_left);
        end
        step();
        ball_exit = 1'b1;
        step();
        rst_n = 1'b1;
        starts = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            ball_exit = (k == 2);
            stopped   = (k == 3);
            if (start === 1'b1 || busy === 1'b1) starts++;
        end
        ball_exit = 1'b0;
        stopped   = 1'b0;
        total++;
        if (starts !== 0 || out_count !== 5'd0) begin
            bad++;
            $display("FAIL midreset_quiet got=%0d/%0d want=0/0",
                     starts, out_count);
        end
        do_go(1'b0);
        wait_start(4, w);
        total++;
        if (w !== 1 || blue_left !== 4'd7) begin
            bad++;
            $display("FAIL midreset_restart got=%0d/%0d want=1/7",
                     w, blue_left);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        go           = 1'b0;
        first_colour = 1'b0;
        ball_exit    = 1'b0;
        exit_colour  = 1'b0;
        stopped      = 1'b0;
        test_reset();
        test_default_run();
        test_alternate();
        test_stopped();
        test_both();
        test_jam();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
